// File: rtl/ariane_pkg.sv
// Shared fetch-path types: the fetch_entry handed to decode and its prediction/exception fields.
// Also holds the default fetch FIFO depth.
package ariane_pkg;

  localparam int FETCH_FIFO_DEPTH = 4;

  localparam logic [63:0] INSTR_PAGE_FAULT = 64'd12;

  typedef struct packed {
    logic [63:0] cause;
    logic [63:0] tval;
    logic        valid;
  } exception;

  typedef struct packed {
    logic [63:0] predict_address;
    logic        predict_taken;
    logic        valid;
  } branchpredict_sbe;

  typedef struct packed {
    logic [63:0]      address;
    logic [31:0]      instruction;
    branchpredict_sbe branch_predict;
    exception         ex;
  } fetch_entry;

endpackage

// File: rtl/fetch_fifo_ctrl.sv
// Pointer and occupancy bookkeeping for fetch_fifo: wr_ptr/rd_ptr/count with push, pop and flush.
import ariane_pkg::*;

module fifo_ctrl #(
  parameter int DEPTH = FETCH_FIFO_DEPTH,
  parameter int PW    = $clog2(DEPTH),
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk_i,
  input  logic          rst_i,
  input  logic          flush_i,
  input  logic          push_i,
  input  logic          pop_i,
  output logic [PW-1:0] wr_ptr_o,
  output logic [PW-1:0] rd_ptr_o,
  output logic [CW-1:0] count_o,
  output logic          full_o,
  output logic          empty_o
);

  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_ok, pop_ok;

  assign full_o  = (count_q == CW'(DEPTH));
  assign empty_o = (count_q == '0);

  // Requests beyond capacity are dropped here as a second line of defence.
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push_ok) wr_ptr_d = wr_ptr_q + PW'(1);
      if (pop_ok)  rd_ptr_d = rd_ptr_q + PW'(1);
      case ({push_ok, pop_ok})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  assign wr_ptr_o = wr_ptr_q;
  assign rd_ptr_o = rd_ptr_q;
  assign count_o  = count_q;

endmodule

// File: rtl/fetch_fifo.sv
// In-order buffer between fetch and decode; locks input after a faulting fetch until flushed.
// Optional combinational pass-through when empty: define FETCH_FIFO_BYPASS_EN.
import ariane_pkg::*;

module fetch_fifo #(
  parameter int DEPTH = FETCH_FIFO_DEPTH,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             flush_i,
  input  logic             in_valid_i,
  output logic             in_ready_o,
  input  logic [63:0]      in_addr_i,
  input  logic [31:0]      in_instr_i,
  input  branchpredict_sbe in_bp_i,
  input  exception         in_ex_i,
  output fetch_entry       fetch_entry_o,
  output logic             fetch_entry_valid_o,
  input  logic             fetch_ack_i,
  output logic [CW-1:0]    count_o
);

  localparam int PW = $clog2(DEPTH);

  // Handshake: a transfer happens on a cycle where valid and ready (or valid and ack) are both high
  // and flush_i is low; in_ready_o depends on registers only, never on fetch_ack_i.
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          full, empty;
  logic          push_acc, store, pop, bypass_take;
  logic          ex_lock_q, ex_lock_d;
  fetch_entry    in_entry;
  fetch_entry    mem_q [DEPTH];
  fetch_entry    mem_d [DEPTH];

  always_comb begin
    in_entry                = '0;
    in_entry.address        = in_addr_i;
    in_entry.instruction    = in_instr_i;
    in_entry.branch_predict = in_bp_i;
    in_entry.ex             = in_ex_i;
  end

  assign in_ready_o = ~full & ~ex_lock_q;
  assign push_acc   = in_valid_i & in_ready_o & ~flush_i;
  assign pop        = ~empty & fetch_ack_i & ~flush_i;
  assign store      = push_acc & ~bypass_take;

`ifdef FETCH_FIFO_BYPASS_EN
  logic bypass_active;
  assign bypass_active       = empty & ~ex_lock_q & ~flush_i;
  assign bypass_take         = bypass_active & in_valid_i & fetch_ack_i;
  assign fetch_entry_valid_o = bypass_active ? in_valid_i : ~empty;
  assign fetch_entry_o       = (bypass_active & in_valid_i) ? in_entry : mem_q[rd_ptr];
`else
  assign bypass_take         = 1'b0;
  assign fetch_entry_valid_o = ~empty;
  assign fetch_entry_o       = mem_q[rd_ptr];
`endif

  fifo_ctrl #(
    .DEPTH (DEPTH),
    .PW    (PW),
    .CW    (CW)
  ) u_ctrl (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .flush_i  (flush_i),
    .push_i   (store),
    .pop_i    (pop),
    .wr_ptr_o (wr_ptr),
    .rd_ptr_o (rd_ptr),
    .count_o  (count_o),
    .full_o   (full),
    .empty_o  (empty)
  );

  always_comb begin
    mem_d = mem_q;
    if (store) mem_d[wr_ptr] = in_entry;
  end

  // Any accepted faulting fetch locks input, including one consumed straight through the bypass.
  always_comb begin
    ex_lock_d = ex_lock_q | (push_acc & in_ex_i.valid);
    if (flush_i) ex_lock_d = 1'b0;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      ex_lock_q <= 1'b0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else begin
      ex_lock_q <= ex_lock_d;
      mem_q     <= mem_d;
    end
  end

endmodule

// File: tb/tb_fetch_fifo.sv
// Bench for fetch_fifo: directed vector table, hand-written corner sequences, and random traffic
// checked against a queue-based model.
module tb_fetch_fifo;
  import ariane_pkg::*;

  localparam int DEPTH = FETCH_FIFO_DEPTH;
  localparam int CW    = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             rst, flush, in_valid, ack;
  logic [63:0]      in_addr;
  logic [31:0]      in_instr;
  branchpredict_sbe in_bp;
  exception         in_ex;
  fetch_entry       entry_o;
  logic             entry_valid, in_ready;
  logic [CW-1:0]    count;

  int n_cmp  = 0;
  int n_fail = 0;

  // clock / reset
  always #5 clk = ~clk;

  fetch_fifo #(.DEPTH(DEPTH)) dut (
    .clk_i               (clk),
    .rst_i               (rst),
    .flush_i             (flush),
    .in_valid_i          (in_valid),
    .in_ready_o          (in_ready),
    .in_addr_i           (in_addr),
    .in_instr_i          (in_instr),
    .in_bp_i             (in_bp),
    .in_ex_i             (in_ex),
    .fetch_entry_o       (entry_o),
    .fetch_entry_valid_o (entry_valid),
    .fetch_ack_i         (ack),
    .count_o             (count)
  );

  typedef struct {
    string       name;
    logic        r, f, v, a, exv;
    logic [63:0] addr;
    int          exp_count;
    logic        exp_valid, exp_ready, chk_head, exp_exv;
    logic [63:0] exp_head;
  } vec_t;

  vec_t vecs[$];

  // scoreboard compare
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // driver tasks
  task automatic set_in(input logic r, input logic f, input logic v, input logic a,
                        input logic exv, input logic [63:0] addr);
    rst      = r;
    flush    = f;
    in_valid = v;
    ack      = a;
    in_addr  = addr;
    in_instr = addr[31:0] ^ 32'h0000_0013;
    in_bp.predict_address = addr + 64'd16;
    in_bp.predict_taken   = addr[2];
    in_bp.valid           = 1'b1;
    in_ex.cause = exv ? INSTR_PAGE_FAULT : 64'd0;
    in_ex.tval  = exv ? addr : 64'd0;
    in_ex.valid = exv;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic void addv(input string nm, input logic r, input logic f, input logic v,
                               input logic a, input logic exv, input logic [63:0] addr,
                               input int ec, input logic ev, input logic er, input logic ch,
                               input logic [63:0] eh, input logic eexv);
    vec_t t;
    t.name = nm; t.r = r; t.f = f; t.v = v; t.a = a; t.exv = exv; t.addr = addr;
    t.exp_count = ec; t.exp_valid = ev; t.exp_ready = er; t.chk_head = ch;
    t.exp_head = eh; t.exp_exv = eexv;
    vecs.push_back(t);
  endfunction

  initial begin
    fetch_entry mq[$];
    bit         mlock;

    set_in(1, 0, 0, 0, 0, 64'd0);
    tick();
    tick();
    set_in(0, 0, 0, 0, 0, 64'd0);
    #1;
    chk("reset_count", 64'(count), 64'd0);
    chk("reset_valid", 64'(entry_valid), 64'd0);
    chk("reset_ready", 64'(in_ready), 64'd1);
    chk("reset_entry_zero", 64'(entry_o == '0), 64'd1);

    // fill from full -> drain order
    addv("t1_rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      addv("t1_push", 0, 0, 1, 0, 0, 64'h80 + 64'(4 * k), k + 1, 1, (k < 3), 1, 64'h80, 0);
    addv("t1_pop", 0, 0, 0, 1, 0, 0, 3, 1, 1, 1, 64'h84, 0);
    addv("t1_pop", 0, 0, 0, 1, 0, 0, 2, 1, 1, 1, 64'h88, 0);
    addv("t1_pop", 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 64'h8C, 0);
    addv("t1_pop", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 4; k++)
      addv("t2_fill", 0, 0, 1, 0, 0, 64'hA0 + 64'(4 * k), k + 1, 1, (k < 3), 1, 64'hA0, 0);
    addv("t2_full_push_ack", 0, 0, 1, 1, 0, 64'hB0, 3, 1, 1, 1, 64'hA4, 0);
    addv("t2_push_after", 0, 0, 1, 0, 0, 64'hB0, 4, 1, 0, 1, 64'hA4, 0);
    addv("t2_drain", 0, 0, 0, 1, 0, 0, 3, 1, 1, 1, 64'hA8, 0);
    addv("t2_drain", 0, 0, 0, 1, 0, 0, 2, 1, 1, 1, 64'hAC, 0);
    addv("t2_drain", 0, 0, 0, 1, 0, 0, 1, 1, 1, 1, 64'hB0, 0);
    addv("t2_drain", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    addv("t4_ex_push", 0, 0, 1, 0, 1, 64'h100, 1, 1, 0, 1, 64'h100, 1);
    addv("t4_locked_push", 0, 0, 1, 0, 0, 64'h104, 1, 1, 0, 1, 64'h100, 1);
    addv("t4_drain", 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0);
    addv("t4_flush", 0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    for (int k = 0; k < 3; k++)
      addv("t5_fill", 0, 0, 1, 0, 0, 64'hC0 + 64'(4 * k), k + 1, 1, 1, 1, 64'hC0, 0);
    addv("t5_flush_push_ack", 0, 1, 1, 1, 0, 64'hCC, 0, 0, 1, 0, 0, 0);
    addv("t5_after", 0, 0, 1, 0, 0, 64'hD0, 1, 1, 1, 1, 64'hD0, 0);
    addv("t5_drain", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);
    addv("t6_fill", 0, 0, 1, 0, 0, 64'hE0, 1, 1, 1, 1, 64'hE0, 0);
    addv("t6_fill", 0, 0, 1, 0, 0, 64'hE4, 2, 1, 1, 1, 64'hE0, 0);
    addv("t6_rst", 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
    addv("t6_after", 0, 0, 1, 0, 0, 64'hE8, 1, 1, 1, 1, 64'hE8, 0);
    addv("t6_drain", 0, 0, 0, 1, 0, 0, 0, 0, 1, 0, 0, 0);

    foreach (vecs[i]) begin
      set_in(vecs[i].r, vecs[i].f, vecs[i].v, vecs[i].a, vecs[i].exv, vecs[i].addr);
      tick();
      set_in(0, 0, 0, 0, 0, 64'd0);
      #1;
      chk({vecs[i].name, "_count"}, 64'(count), 64'(vecs[i].exp_count));
      chk({vecs[i].name, "_valid"}, 64'(entry_valid), 64'(vecs[i].exp_valid));
      chk({vecs[i].name, "_ready"}, 64'(in_ready), 64'(vecs[i].exp_ready));
      if (vecs[i].chk_head) begin
        chk({vecs[i].name, "_head"}, entry_o.address, vecs[i].exp_head);
        chk({vecs[i].name, "_instr"}, 64'(entry_o.instruction),
            64'(vecs[i].exp_head[31:0] ^ 32'h0000_0013));
        chk({vecs[i].name, "_exv"}, 64'(entry_o.ex.valid), 64'(vecs[i].exp_exv));
        chk({vecs[i].name, "_cause"}, entry_o.ex.cause,
            vecs[i].exp_exv ? INSTR_PAGE_FAULT : 64'd0);
      end
    end

    // continuous push+ack streaming across pointer wrap
`ifdef FETCH_FIFO_BYPASS_EN
    for (int k = 0; k < 12; k++) begin
      set_in(0, 0, 1, 1, 0, 64'h200 + 64'(4 * k));
      #1;
      chk("t3_byp_valid", 64'(entry_valid), 64'd1);
      chk("t3_byp_head", entry_o.address, 64'h200 + 64'(4 * k));
      tick();
      chk("t3_byp_count", 64'(count), 64'd0);
    end
    set_in(0, 0, 0, 0, 0, 64'd0);
    tick();
`else
    for (int k = 0; k < 12; k++) begin
      set_in(0, 0, 1, (k > 0), 0, 64'h200 + 64'(4 * k));
      #1;
      if (k > 0) chk("t3_head", entry_o.address, 64'h200 + 64'(4 * (k - 1)));
      tick();
      chk("t3_count", 64'(count), 64'd1);
    end
    set_in(0, 0, 0, 1, 0, 64'd0);
    #1;
    chk("t3_last_head", entry_o.address, 64'h22C);
    tick();
    chk("t3_end_count", 64'(count), 64'd0);
    set_in(0, 0, 0, 0, 0, 64'd0);
`endif

    // random traffic against the queue model
    mq.delete();
    mlock = 1'b0;
    set_in(1, 0, 0, 0, 0, 64'd0);
    tick();
    for (int c = 0; c < 600; c++) begin
      fetch_entry cur, exp_e;
      logic r, f, v, a;
      bit   byp, e_ready, e_valid;
      r = ($urandom_range(0, 99) < 2);
      f = ($urandom_range(0, 99) < 4);
      v = ($urandom_range(0, 99) < 70);
      a = ($urandom_range(0, 99) < 60);
      cur.address                        = {$urandom, $urandom};
      cur.instruction                    = $urandom;
      cur.branch_predict.predict_address = {$urandom, $urandom};
      cur.branch_predict.predict_taken   = 1'($urandom_range(0, 1));
      cur.branch_predict.valid           = 1'($urandom_range(0, 1));
      cur.ex.cause = {$urandom, $urandom};
      cur.ex.tval  = {$urandom, $urandom};
      cur.ex.valid = ($urandom_range(0, 99) < 6);
      rst = r; flush = f; in_valid = v; ack = a;
      in_addr = cur.address; in_instr = cur.instruction;
      in_bp = cur.branch_predict; in_ex = cur.ex;
      #1;
      byp = 1'b0;
`ifdef FETCH_FIFO_BYPASS_EN
      byp = (mq.size() == 0) && !mlock && !f;
`endif
      e_ready = !mlock && (mq.size() < DEPTH);
      e_valid = byp ? v : (mq.size() != 0);
      chk("rnd_count", 64'(count), 64'(mq.size()));
      chk("rnd_ready", 64'(in_ready), 64'(e_ready));
      chk("rnd_valid", 64'(entry_valid), 64'(e_valid));
      if (e_valid) begin
        exp_e = byp ? cur : mq[0];
        chk("rnd_head_addr", entry_o.address, exp_e.address);
        chk("rnd_head_entry", 64'(entry_o == exp_e), 64'd1);
      end
      if (r || f) begin
        mq.delete();
        mlock = 1'b0;
      end else if (byp && v && a) begin
        mlock = mlock | cur.ex.valid;
      end else begin
        if (e_valid && a) void'(mq.pop_front());
        if (v && e_ready) begin
          mq.push_back(cur);
          mlock = mlock | cur.ex.valid;
        end
      end
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
